dual_ram_arbiter: RTL

- Two-client arbiter that shares one 64x8 dual-port RAM (separate read and write address ports, registered read data) between two requesters.
- Each client issues single-byte read or write commands through a req/gnt handshake.
- The arbiter grants one command per cycle using round-robin, with an optional lock for atomic read-modify-write.
- It drives the RAM control and data ports and routes the registered read data back to the requesting client.

---
 rtl/dual_ram_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dual_ram_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM between two single-byte clients,
// with a lock for atomic RMW. Define RAM_ARB_STATS_EN to add grant/conflict counters.
module dual_ram_arbiter #(
  parameter int AW    = 6,
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          ram_w_en,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  output logic [DW-1:0] ram_wdata,
`ifdef RAM_ARB_STATS_EN
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_gnt0,
  output logic [CNT_W-1:0] stat_gnt1,
  output logic [CNT_W-1:0] stat_conflict,
`endif
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} lock_e;

  lock_e         state;
  logic          rr;       // 0: client0 wins a tie, 1: client1 wins
  logic          g0, g1;
  logic          acc, sel_we, sel_lock, rd_go;
  logic [AW-1:0] sel_addr, waddr_q, raddr_q;
  logic [DW-1:0] sel_wdata, wdata_q;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state)
      LOCKED0: g0 = req0;
      LOCKED1: g1 = req1;
      default: begin
        if (req0 && req1) begin
          g0 = ~rr;
          g1 = rr;
        end else begin
          g0 = req0;
          g1 = req1;
        end
      end
    endcase
  end

  // Grants are forced low while reset is held so nothing reaches the RAM.
  assign gnt0      = g0 & rst_n;
  assign gnt1      = g1 & rst_n;
  assign acc       = gnt0 | gnt1;
  assign sel_we    = gnt0 ? we0    : we1;
  assign sel_addr  = gnt0 ? addr0  : addr1;
  assign sel_wdata = gnt0 ? wdata0 : wdata1;
  assign sel_lock  = gnt0 ? lock0  : lock1;
  assign rd_go     = acc & ~sel_we;

  // Idle cycles replay the last driven address/data to keep the RAM pins quiet.
  assign ram_w_en  = acc & sel_we;
  assign ram_waddr = ram_w_en ? sel_addr  : waddr_q;
  assign ram_wdata = ram_w_en ? sel_wdata : wdata_q;
  assign ram_raddr = rd_go    ? sel_addr  : raddr_q;
  assign rdata     = (rvalid0 | rvalid1) ? ram_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNLOCKED;
      rr      <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      if (ram_w_en) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (rd_go) raddr_q <= sel_addr;
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      case (state)
        UNLOCKED: begin
          if (acc) begin
            if (sel_lock) state <= gnt0 ? LOCKED0 : LOCKED1;
            else          rr    <= gnt0;
          end
        end
        // Owner leaves the lock either by an unlocked grant or by dropping lock
        // while idle; both reduce to lockN == 0 because gntN == reqN here.
        LOCKED0: if (!lock0) begin state <= UNLOCKED; rr <= 1'b1; end
        LOCKED1: if (!lock1) begin state <= UNLOCKED; rr <= 1'b0; end
        default: state <= UNLOCKED;
      endcase
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic conflict;
  assign conflict = req0 & req1 & (state == UNLOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else if (stat_clr) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt0 && stat_gnt0 != '1)         stat_gnt0     <= stat_gnt0 + 1'b1;
      if (gnt1 && stat_gnt1 != '1)         stat_gnt1     <= stat_gnt1 + 1'b1;
      if (conflict && stat_conflict != '1) stat_conflict <= stat_conflict + 1'b1;
    end
  end
`endif

endmodule
